// File: rtl/button_gesture_pkg.sv
// button_gesture_pkg: shared state type and sizing helper for the button gesture decoder
package button_gesture_pkg;
  typedef enum logic [2:0] {
    INIT,
    WAIT_RELEASE,
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } gesture_state_t;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running one-cycle tick every TICK_CYCLES clocks, restartable by clr
module ms_tick_gen #(
  parameter int TICK_CYCLES = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_CYCLES - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/button_gesture.sv
// button_gesture: turns a debounced button level into press/release/click/long-press/repeat pulses
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 5,
  parameter int TICK_CYCLES   = 1_000_000 / CLK_PERIOD_NS,
  parameter int LONG_PRESS_MS = 800,
  parameter int REPEAT_MS     = 200,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic held,
  output logic press,
  output logic release_evt,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_evt
);
  localparam int MS_MAX = max3(LONG_PRESS_MS, REPEAT_MS, DOUBLE_GAP_MS);
  localparam int MS_W   = $clog2(MS_MAX + 1);
  gesture_state_t state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [6:0] out_q, out_d;
  logic prev_q, tick, clr, rise, fall, long_hit, rep_hit, gap_hit;
  logic press_d, rel_d, single_d, double_d, long_d, rep_d;
  ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );
  assign rise     = clean & ~prev_q;
  assign fall     = ~clean & prev_q;
  assign long_hit = tick && ms_cnt_q == MS_W'(LONG_PRESS_MS - 1);
  assign rep_hit  = tick && ms_cnt_q == MS_W'(REPEAT_MS - 1);
  assign gap_hit  = tick && ms_cnt_q == MS_W'(DOUBLE_GAP_MS - 1);
  assign {held, press, release_evt, single_click, double_click, long_press, repeat_evt} = out_q;
  always_comb begin
    state_d  = state_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    unique case (state_q)
      INIT:         state_d = clean ? WAIT_RELEASE : IDLE;
      WAIT_RELEASE: state_d = fall ? IDLE : WAIT_RELEASE;
      IDLE: if (rise) begin
        state_d = PRESSED;
        press_d = 1'b1;
      end
      PRESSED: if (fall) begin
        state_d = WAIT_SECOND;
        rel_d   = 1'b1;
      end else if (long_hit) begin
        state_d = LONG_HELD;
        long_d  = 1'b1;
      end
      LONG_HELD: if (fall) begin
        state_d = IDLE;
        rel_d   = 1'b1;
      end else if (rep_hit) rep_d = 1'b1;
      WAIT_SECOND: if (rise) begin
        state_d = SECOND_PRESSED;
        press_d = 1'b1;
      end else if (gap_hit) begin
        state_d  = IDLE;
        single_d = 1'b1;
      end
      SECOND_PRESSED: if (fall) begin
        state_d  = IDLE;
        rel_d    = 1'b1;
        double_d = 1'b1;
      end else if (long_hit) begin
        state_d = LONG_HELD;
        long_d  = 1'b1;
      end
      default: state_d = INIT;
    endcase
    clr      = (state_d != state_q) || rep_d;
    ms_cnt_d = clr ? '0 : (tick && ms_cnt_q != MS_W'(MS_MAX)) ? ms_cnt_q + 1'b1 : ms_cnt_q;
    out_d    = {state_d inside {PRESSED, LONG_HELD, SECOND_PRESSED},
                press_d, rel_d, single_d, double_d, long_d, rep_d};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= INIT;
      ms_cnt_q <= '0;
      prev_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      prev_q   <= clean;
      out_q    <= out_d;
    end
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed scenarios checked against a cycle-timed gesture model
module tb_button_gesture;
  localparam int TC = 10, LP_MS = 8, RP_MS = 3, GP_MS = 5;
  localparam int LP = LP_MS * TC, RP = RP_MS * TC, GP = GP_MS * TC;
  localparam int M_BOOT = 0, M_IGNORE = 1, M_IDLE = 2, M_DOWN = 3, M_LONG = 4, M_GAP = 5, M_DOWN2 = 6;
  localparam int HE = 6, PR = 5, RL = 4, SC = 3, DC = 2, LO = 1, RE = 0;
  logic clk = 1'b0, rst_n = 1'b0, clean = 1'b0;
  logic held, press, release_evt, single_click, double_click, long_press, repeat_evt;
  logic [6:0] o, e;
  logic r, f;
  int md, nx, mt, mp, cyc;
  int checks = 0, passed = 0;
  int n[7], b[7], c[7];
  string nm[7] = '{"repeat_evt", "long_press", "double_click", "single_click", "release", "press", "held"};
  button_gesture #(
    .CLK_PERIOD_NS(5),
    .TICK_CYCLES  (TC),
    .LONG_PRESS_MS(LP_MS),
    .REPEAT_MS    (RP_MS),
    .DOUBLE_GAP_MS(GP_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clean       (clean),
    .held        (held),
    .press       (press),
    .release_evt (release_evt),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_evt  (repeat_evt)
  );
  always #5 clk = ~clk;
  assign o = {held, press, release_evt, single_click, double_click, long_press, repeat_evt};
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      md = M_BOOT;
      mp = 0;
      mt = 0;
      e  = '0;
    end else begin
      r  = clean && mp == 0;
      f  = !clean && mp == 1;
      mp = clean ? 1 : 0;
      mt++;
      e  = '0;
      nx = md;
      case (md)
        M_BOOT:   nx = clean ? M_IGNORE : M_IDLE;
        M_IGNORE: if (f) nx = M_IDLE;
        M_IDLE:   if (r) begin nx = M_DOWN; e[PR] = 1; end
        M_DOWN:   if (f) begin nx = M_GAP; e[RL] = 1; end
                  else if (mt == LP) begin nx = M_LONG; e[LO] = 1; end
        M_LONG:   if (f) begin nx = M_IDLE; e[RL] = 1; end
                  else if (mt == RP) begin e[RE] = 1; mt = 0; end
        M_GAP:    if (r) begin nx = M_DOWN2; e[PR] = 1; end
                  else if (mt == GP) begin nx = M_IDLE; e[SC] = 1; end
        M_DOWN2:  if (f) begin nx = M_IDLE; e[RL] = 1; e[DC] = 1; end
                  else if (mt == LP) begin nx = M_LONG; e[LO] = 1; end
        default:  nx = M_BOOT;
      endcase
      if (nx != md) mt = 0;
      md = nx;
      e[HE] = md == M_DOWN || md == M_LONG || md == M_DOWN2;
    end
  always @(negedge clk) begin
    for (int i = 0; i < 7; i++) begin
      chk(nm[i], int'(o[i]), int'(e[i]));
      if (o[i]) begin
        n[i]++;
        c[i] = cyc;
      end
    end
    chk("one_event", int'($countones(o[3:0]) <= 1), 1);
  end
  task automatic run(input logic v, input int k);
    clean = v;
    repeat (k) @(negedge clk);
  endtask
  task automatic snap();
    for (int i = 0; i < 7; i++) b[i] = n[i];
  endtask
  function automatic int d(input int i);
    return n[i] - b[i];
  endfunction
  initial begin
    for (int i = 0; i < 7; i++) begin
      n[i] = 0;
      c[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(o), 0);
    rst_n = 1'b1;
    run(0, 5);
    snap();
    run(1, 30);
    run(0, 60);
    chk("s1_press", d(PR), 1);
    chk("s1_release", d(RL), 1);
    chk("s1_single", d(SC), 1);
    chk("s1_single_delay", c[SC] - c[RL], 50);
    chk("s1_held_cycles", d(HE), 30);
    chk("s1_no_double", d(DC), 0);
    snap();
    run(1, 30);
    run(0, 20);
    run(1, 30);
    run(0, 60);
    chk("s2_press", d(PR), 2);
    chk("s2_release", d(RL), 2);
    chk("s2_double", d(DC), 1);
    chk("s2_double_with_release", c[DC] - c[RL], 0);
    chk("s2_no_single", d(SC), 0);
    snap();
    run(1, 150);
    run(0, 60);
    chk("s3_long", d(LO), 1);
    chk("s3_long_delay", c[LO] - c[PR], 80);
    chk("s3_repeats", d(RE), 2);
    chk("s3_last_repeat", c[RE] - c[LO], 60);
    chk("s3_release", d(RL), 1);
    chk("s3_no_click", d(SC) + d(DC), 0);
    rst_n = 1'b0;
    clean = 1'b1;
    snap();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(1, 40);
    run(0, 10);
    chk("s4_no_pulses", d(PR) + d(RL) + d(SC) + d(DC) + d(LO) + d(RE), 0);
    chk("s4_held_low", d(HE), 0);
    snap();
    run(1, 10);
    run(0, 60);
    chk("s4_next_press", d(PR), 1);
    chk("s4_next_single", d(SC), 1);
    snap();
    run(1, 80);
    run(0, 60);
    chk("s5_no_long", d(LO), 0);
    chk("s5_release", d(RL), 1);
    chk("s5_single", d(SC), 1);
    snap();
    run(1, 10);
    run(0, 20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 60);
    chk("s5_abort_release", d(RL), 1);
    chk("s5_abort_no_single", d(SC), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
